// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage: word RAM behind an iaddr/idata/iready_n
// handshake with programmable wait states, plus a word-write port for program download.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    output logic        iready_n,
    output logic        ifault,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t      state, state_d;
    logic [31:0] tag, tag_d;
    logic [3:0]  wcnt, wcnt_d;
    logic [31:0] idata_d;
    logic        ifault_d;
    logic        iready_n_d;
    logic        tag_valid, tag_valid_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] tag_idx;
    logic [IDX_W-1:0] load_idx;
    logic             tag_fault;
    logic             load_legal;
    logic             load_hit;

    // Unsigned compare plus subtraction keeps the range check free of wraparound at the top of the map.
    function automatic logic in_map(input logic [31:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IDX_W-1:0] index_of(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    assign tag_idx    = index_of(tag);
    assign tag_fault  = !in_map(tag);
    assign load_idx   = index_of(load_addr);
    assign load_legal = in_map(load_addr);
    assign load_hit   = load_we && load_legal && (load_idx == tag_idx);

    always_ff @(posedge clk) begin
        if (load_we && load_legal) begin
            mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tag       <= 32'h0;
            wcnt      <= 4'd0;
            idata     <= NOP_WORD;
            ifault    <= 1'b0;
            iready_n  <= 1'b1;
            tag_valid <= 1'b0;
        end else begin
            state     <= state_d;
            tag       <= tag_d;
            wcnt      <= wcnt_d;
            idata     <= idata_d;
            ifault    <= ifault_d;
            iready_n  <= iready_n_d;
            tag_valid <= tag_valid_d;
        end
    end

    // A write hitting the served word forces a re-fetch, so the completing read never races a write.
    always_comb begin
        state_d     = state;
        tag_d       = tag;
        wcnt_d      = wcnt;
        idata_d     = idata;
        ifault_d    = ifault;
        iready_n_d  = iready_n;
        tag_valid_d = tag_valid;
        case (state)
            S_IDLE: begin
                state_d = S_WAIT;
                tag_d   = iaddr;
                wcnt_d  = WAIT_INIT;
            end
            S_WAIT: begin
                if (iaddr != tag) begin
                    tag_d  = iaddr;
                    wcnt_d = WAIT_INIT;
                end else if (load_hit) begin
                    wcnt_d = WAIT_INIT;
                end else if (wcnt != 4'd0) begin
                    wcnt_d = wcnt - 4'd1;
                end else begin
                    idata_d     = tag_fault ? NOP_WORD : mem[tag_idx];
                    ifault_d    = tag_fault;
                    iready_n_d  = 1'b0;
                    tag_valid_d = 1'b1;
                    state_d     = S_READY;
                end
            end
            S_READY: begin
                if (iaddr != tag) begin
                    iready_n_d  = 1'b1;
                    tag_d       = iaddr;
                    wcnt_d      = WAIT_INIT;
                    tag_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end else if (load_hit && tag_valid) begin
                    iready_n_d  = 1'b1;
                    wcnt_d      = WAIT_INIT;
                    tag_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (2 and 0 wait states) share one stimulus stream and
// are compared against a latency/memory reference model kept in the bench.
module tb_imem_responder;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic [31:0] idata2, idata0;
    logic        iready2_n, iready0_n;
    logic        ifault2, ifault0;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mref [DEPTH];
    logic [31:0] cur;
    int          age;

    always #5 clk = ~clk;

    imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .NOP_WORD(NOP)) dut2 (
        .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata2), .iready_n(iready2_n), .ifault(ifault2),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .NOP_WORD(NOP)) dut0 (
        .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata0), .iready_n(iready0_n), .ifault(ifault0),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    function automatic bit legal(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH) && (a % 4 == 0);
    endfunction

    function automatic int index_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return int'(d >> 2) % DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // An access is ready once it has been undisturbed for WAIT_CYCLES+2 edges counting its start edge.
    task automatic modelEdge();
        bit start;
        bit wr;
        wr    = load_we && legal(load_addr);
        start = (age == 0) || (iaddr != cur) || (wr && index_of(load_addr) == index_of(cur));
        if (wr) mref[index_of(load_addr)] = load_data;
        if (start) begin
            cur = iaddr;
            age = 1;
        end else if (age < 1000) begin
            age++;
        end
    endtask

    task automatic checkOutput();
        logic [31:0] expData;
        logic        expFault;
        expFault = !legal(cur);
        expData  = expFault ? NOP : mref[index_of(cur)];
        chk("iready_n_w2", {31'b0, iready2_n}, {31'b0, !(age >= 4)});
        if (age >= 4) begin
            chk("idata_w2", idata2, expData);
            chk("ifault_w2", {31'b0, ifault2}, {31'b0, expFault});
        end
        chk("iready_n_w0", {31'b0, iready0_n}, {31'b0, !(age >= 2)});
        if (age >= 2) begin
            chk("idata_w0", idata0, expData);
            chk("ifault_w0", {31'b0, ifault0}, {31'b0, expFault});
        end
    endtask

    task automatic checkReset();
        chk("rst_iready_n_w2", {31'b0, iready2_n}, 32'd1);
        chk("rst_idata_w2", idata2, NOP);
        chk("rst_ifault_w2", {31'b0, ifault2}, 32'd0);
        chk("rst_iready_n_w0", {31'b0, iready0_n}, 32'd1);
        chk("rst_idata_w0", idata0, NOP);
        chk("rst_ifault_w0", {31'b0, ifault0}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input bit we, input logic [31:0] la,
                                 input logic [31:0] ld);
        iaddr     = a;
        load_we   = we;
        load_addr = la;
        load_data = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic hold(input logic [31:0] a, input int n);
        applyStimulus(a, 1'b0, 32'h0, 32'h0);
        repeat (n) tick();
    endtask

    // Drops reset away from any edge, checks the immediate response, releases after one edge.
    task automatic pulseReset();
        #3;
        rst = 1'b0;
        #1;
        age = 0;
        checkReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] randAddr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5) return BASE + 32'(4 * $urandom_range(0, 63));
        if (r == 6) return BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
        if (r == 7) return BASE + 32'(4 * (DEPTH - 1));
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return BASE - 32'd4;
            2:       return BASE + 32'(4 * DEPTH);
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        age = 0;
        cur = 32'h0;
        rst = 1'b1;
        applyStimulus(BASE, 1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        $display("[TB] checking reset values");
        checkReset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] preloading program window and last word");
        for (int i = 0; i < 64; i++) begin
            applyStimulus(BASE, 1'b1, BASE + 32'(4 * i), (i == 0) ? 32'h0000_0093 : $urandom);
            tick();
        end
        applyStimulus(BASE, 1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'hCAFE_0001);
        tick();

        $display("[TB] first fetch after reset, memory retained");
        pulseReset();
        hold(BASE, 5);
        chk("first_word", idata2, 32'h0000_0093);

        $display("[TB] sequential fetch");
        hold(BASE + 32'd4, 4);
        hold(BASE + 32'd8, 4);
        hold(BASE + 32'd12, 2);
        hold(BASE + 32'd16, 2);

        $display("[TB] branch during wait");
        hold(BASE, 2);
        hold(BASE + 32'h40, 5);

        $display("[TB] faulting accesses");
        hold(BASE + 32'd2, 5);
        hold(32'h0000_0000, 5);
        hold(BASE + 32'(4 * DEPTH), 5);
        hold(BASE + 32'(4 * (DEPTH - 1)), 5);

        $display("[TB] load hitting the served word");
        hold(BASE + 32'd4, 5);
        applyStimulus(BASE + 32'd4, 1'b1, BASE + 32'd4, 32'hDEAD_BEEF);
        tick();
        hold(BASE + 32'd4, 4);
        chk("reload_word", idata2, 32'hDEAD_BEEF);

        $display("[TB] reset during wait");
        hold(BASE + 32'd8, 2);
        pulseReset();
        hold(BASE + 32'd8, 5);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            bit          we;
            logic [31:0] la;
            int          r;
            a  = ($urandom_range(0, 3) == 0) ? randAddr() : iaddr;
            r  = int'($urandom_range(0, 19));
            we = (r < 4);
            la = 32'h0;
            if (r < 2)       la = BASE + 32'(4 * $urandom_range(0, 63));
            else if (r == 2) la = a;
            else if (r == 3) la = (r % 2 == 0) ? BASE - 32'd4 : BASE + 32'(4 * $urandom_range(0, 63)) + 32'd1;
            applyStimulus(a, we, la, $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
